// File: rtl/screen_draw_ctrl_if.sv
// screen_draw_ctrl_if
// Bundles everything screen_draw_ctrl exchanges with the outside world except
// clock and reset.
//   Request side : start, sel (0 start, 1 game-over, 2 win, 3 invalid), busy,
//                  done, timeout_err.
//   Drawer side  : packed drawer outputs drw_x/drw_y/drw_c (drawer k in slice k),
//                  one-hot drw_en and the shared active-low drw_resetn.
//   VGA side     : vga_x, vga_y, vga_c, vga_plot.
// master = game FSM / drawers / testbench side, slave = the controller.
interface screen_draw_ctrl_if;
    logic        start;
    logic [1:0]  sel;
    logic [23:0] drw_x;
    logic [20:0] drw_y;
    logic [8:0]  drw_c;
    logic [2:0]  drw_en;
    logic        drw_resetn;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_c;
    logic        vga_plot;
    logic        busy;
    logic        done;
    logic        timeout_err;

    modport master (
        output start, sel, drw_x, drw_y, drw_c,
        input  drw_en, drw_resetn, vga_x, vga_y, vga_c, vga_plot,
               busy, done, timeout_err
    );

    modport slave (
        input  start, sel, drw_x, drw_y, drw_c,
        output drw_en, drw_resetn, vga_x, vga_y, vga_c, vga_plot,
               busy, done, timeout_err
    );
endinterface

// File: rtl/screen_draw_ctrl.sv
// screen_draw_ctrl
// Sequences one full-screen image draw: arms the selected ROM drawer, forwards
// its pixel stream to the VGA adapter through a 2-stage pipeline that lines the
// coordinates up with the drawer's 1-cycle ROM colour, detects end of frame (or
// a stall via the cycle budget) and reports done / timeout.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - screen_draw_ctrl_if.slave (request, drawer and VGA signals)
// Parameters: WIDTH/HEIGHT screen size, TIMEOUT max DRAW cycles before abort.
module screen_draw_ctrl #(
    parameter int WIDTH   = 160,
    parameter int HEIGHT  = 120,
    parameter int TIMEOUT = 40000
) (
    input  logic               clk,
    input  logic               rst,
    screen_draw_ctrl_if.slave  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_DRAW  = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [7:0]  LAST_X   = 8'(WIDTH - 1);
    localparam logic [6:0]  LAST_Y   = 7'(HEIGHT - 1);
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    logic [2:0]  state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic        seen_last_q, seen_last_d;
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_err_q, timeout_err_d;
    logic        flush_q, flush_d;

    logic [7:0]  x1_q;
    logic [6:0]  y1_q;
    logic        v1_q;
    logic [7:0]  vga_x_q;
    logic [6:0]  vga_y_q;
    logic [2:0]  vga_c_q;
    logic        vga_plot_q;

    // Unpack the drawer buses; slot 3 exists only so an index of sel_q is
    // always in range (sel_q never holds 3).
    logic [7:0] dx_w [4];
    logic [6:0] dy_w [4];
    logic [2:0] dc_w [4];
    logic [2:0] onehot_w;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_drawer
            assign dx_w[gi]     = bus.drw_x[8*gi +: 8];
            assign dy_w[gi]     = bus.drw_y[7*gi +: 7];
            assign dc_w[gi]     = bus.drw_c[3*gi +: 3];
            assign onehot_w[gi] = (sel_q == 2'(gi));
        end
    endgenerate
    assign dx_w[3] = '0;
    assign dy_w[3] = '0;
    assign dc_w[3] = '0;

    logic [7:0] sel_x;
    logic [6:0] sel_y;
    logic [2:0] sel_c;
    logic       at_last;

    assign sel_x   = dx_w[sel_q];
    assign sel_y   = dy_w[sel_q];
    assign sel_c   = dc_w[sel_q];
    assign at_last = (sel_x == LAST_X) && (sel_y == LAST_Y);

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        seen_last_d   = seen_last_q;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
        flush_d       = flush_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && (bus.sel != 2'd3)) begin
                    sel_d         = bus.sel;
                    timeout_err_d = 1'b0;
                    state_d       = S_ARM;
                end
            end
            S_ARM: begin
                seen_last_d = 1'b0;
                cnt_d       = '0;
                flush_d     = 1'b0;
                state_d     = S_DRAW;
            end
            S_DRAW: begin
                if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
                if (at_last) begin
                    seen_last_d = 1'b1;
                end
                if (cnt_q == CNT_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_FLUSH;
                end else if (seen_last_q && !at_last) begin
                    // The drawer has moved past the bottom-right pixel.
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // Two cycles: flush_q is 0 on entry, 1 on the second cycle.
                flush_d = ~flush_q;
                if (flush_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            sel_q         <= 2'd0;
            seen_last_q   <= 1'b0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            seen_last_q   <= seen_last_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
            flush_q       <= flush_d;
        end
    end

    // Stage 1 holds the drawer address; stage 2 pairs it with the ROM colour
    // that appears one cycle after the address, so vga_c matches vga_x/vga_y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1_q       <= '0;
            y1_q       <= '0;
            v1_q       <= 1'b0;
            vga_x_q    <= '0;
            vga_y_q    <= '0;
            vga_c_q    <= '0;
            vga_plot_q <= 1'b0;
        end else begin
            v1_q <= (state_q == S_DRAW);
            if (state_q == S_DRAW) begin
                x1_q <= sel_x;
                y1_q <= sel_y;
            end
            vga_x_q    <= x1_q;
            vga_y_q    <= y1_q;
            vga_c_q    <= sel_c;
            vga_plot_q <= v1_q;
        end
    end

    // Drawers stay out of reset through FLUSH so the ROM colour of the last
    // captured address is still valid while the pipeline drains.
    assign bus.drw_en      = ((state_q == S_ARM) || (state_q == S_DRAW)) ? onehot_w : 3'b000;
    assign bus.drw_resetn  = (state_q == S_ARM) || (state_q == S_DRAW) || (state_q == S_FLUSH);
    assign bus.vga_x       = vga_x_q;
    assign bus.vga_y       = vga_y_q;
    assign bus.vga_c       = vga_c_q;
    assign bus.vga_plot    = vga_plot_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.timeout_err = timeout_err_q;
endmodule
